reset_sequencer: RTL
====================

# reset_sequencer

Parametrised clock/reset sequencer for multi-domain designs. It controls the reset of an external MMCM/PLL and monitors that PLL's lock, then releases `NUM_DOMAINS` active-high synchronous resets in a staged order. It re-sequences automatically on lock loss, lock timeout, or software request. It sits between board reset and every downstream reset consumer, replacing the single-domain, single-shot reset counter.

## Interface
- `NUM_DOMAINS`, 4: number of reset outputs (1..16).
- `PLL_RST_CYCLES`, 16: cycles `PLL_RESET_OUT` is held high per PLL reset pulse (≥1).
- `STRETCH_CYCLES`, 32: cycles of stable lock required before release begins (≥1).
- `STAGE_DELAY`, 8: cycles between consecutive domain releases (≥1).
- `LOCK_TIMEOUT`, 65535: cycles to wait for lock before re-pulsing PLL reset (≥2).
- `SYNC_STAGES`, 2: synchroniser depth for `RESET_N_IN` deassertion and `LOCKED_IN` (≥2).

Ports:
- `CLK_IN` in 1: free-running reference clock (not the PLL output).
- `RESET_N_IN` in 1: asynchronous, active-low reset. Assertion is immediate; deassertion passes through a `SYNC_STAGES` synchroniser.
- `LOCKED_IN` in 1: PLL lock, asynchronous; synchronised internally.
- `SW_RESET_IN` in 1: synchronous software re-sequence request, level-sampled.
- `PLL_RESET_OUT` out 1: PLL reset, active-high.
- `RESET_OUT` out `NUM_DOMAINS`: per-domain resets, active-high. Bit 0 releases first.
- `READY_OUT` out 1: all domains released and lock present.
- `LOCK_LOSS_COUNT_OUT` out 8: saturating count of lock losses seen in RUN or RELEASE.
- `STATE_OUT` out 3: current FSM state encoding, for debug.

## Operation
- FSM states: PLL_RST=0, WAIT_LOCK=1, STRETCH=2, RELEASE=3, RUN=4. All other encodings go to PLL_RST.
- One shared cycle counter, width `$clog2` of the largest of `PLL_RST_CYCLES`, `STRETCH_CYCLES`, `STAGE_DELAY`, `LOCK_TIMEOUT`. It clears on every state change.
- Domain index counter `idx`, width `$clog2(NUM_DOMAINS+1)`.
- **PLL_RST**: `PLL_RESET_OUT`=1, all `RESET_OUT`=1. After `PLL_RST_CYCLES` cycles, go to WAIT_LOCK.
- **WAIT_LOCK**: `PLL_RESET_OUT`=0.
  - `lock_s`=1: go to STRETCH.
  - Counter reaches `LOCK_TIMEOUT`-1 with no lock: go to PLL_RST.
- **STRETCH**: counts cycles with `lock_s`=1.
  - `lock_s`=0: go to WAIT_LOCK with counter cleared.
  - After `STRETCH_CYCLES` cycles: go to RELEASE with `idx`=0.
- **RELEASE**:
  - On entry edge, clear `RESET_OUT[0]`.
  - Every `STAGE_DELAY` cycles thereafter, clear `RESET_OUT[idx+1]` and increment `idx`.
  - On the edge that clears the last bit, set `READY_OUT`=1 and go to RUN.
  - If `NUM_DOMAINS`=1, go straight to RUN on the entry edge.
- **RUN**: holds the released state.
- Lock loss: `lock_s`=0 while in RELEASE or RUN.
  - On the next edge, set all `RESET_OUT`=1 and `READY_OUT`=0.
  - Increment `LOCK_LOSS_COUNT_OUT`, saturating at 255.
  - Go to WAIT_LOCK.
- Software reset: `SW_RESET_IN`=1 in STRETCH, RELEASE or RUN.
  - On the next edge, set all `RESET_OUT`=1 and `READY_OUT`=0, then go to STRETCH with counter cleared. `PLL_RESET_OUT` is not pulsed.
  - While `SW_RESET_IN` stays high, the FSM stays in STRETCH with the counter cleared.
  - `SW_RESET_IN` is ignored in PLL_RST and WAIT_LOCK.
- Priority when events coincide: async reset > lock loss > `SW_RESET_IN` > counter expiry. Lock loss and `SW_RESET_IN` in the same cycle go to WAIT_LOCK and increment the count.
- Release is monotonic: a domain's reset never deasserts before a lower-index domain's reset.

## Timing
- While `RESET_N_IN`=0, outputs take these values asynchronously:
  - `PLL_RESET_OUT`=1
  - `RESET_OUT`=all ones
  - `READY_OUT`=0
  - `LOCK_LOSS_COUNT_OUT`=0
  - `STATE_OUT`=0
- E0 is the first rising edge at which the synchronised internal reset is low. This is `SYNC_STAGES` edges after `RESET_N_IN` rises.
- `PLL_RESET_OUT` falls at edge E0+`PLL_RST_CYCLES`.
- `lock_s` lags `LOCKED_IN` by `SYNC_STAGES` edges.
- All outputs are registered; there is no combinational path from input to output.
- Lock-loss response latency: `LOCKED_IN` falling to `RESET_OUT` all ones is `SYNC_STAGES`+1 edges.
- `SW_RESET_IN` to `RESET_OUT` all ones is 1 edge.

## Test plan
- Default parameters, `LOCKED_IN`=1 throughout, release `RESET_N_IN` -> the following, then hold steady for 1000 cycles:
  - `PLL_RESET_OUT` falls at E16.
  - STRETCH is entered at E17.
  - `RESET_OUT[0..3]` fall at E49, E57, E65 and E73.
  - `READY_OUT` rises at E73.
- `LOCKED_IN` stays 0 with `LOCK_TIMEOUT`=100 -> `PLL_RESET_OUT` pulses for 16 cycles every 116 cycles; `RESET_OUT` stays 0xF.
- In RUN, drop `LOCKED_IN` for 5 cycles, then restore -> all resets assert 3 edges after the drop and `LOCK_LOSS_COUNT_OUT`=1. Re-release completes with no PLL pulse.
- In STRETCH, glitch `LOCKED_IN` low for 1 cycle at stretch count 20 -> the stretch restarts from 0; the first release is delayed by the full 32 cycles after lock returns.
- In RELEASE, after `RESET_OUT[1]` has fallen, pulse `SW_RESET_IN` for 1 cycle -> `RESET_OUT`=0xF next edge, STRETCH is re-entered, the full staged release repeats, and `LOCK_LOSS_COUNT_OUT` is unchanged.
- Assert `RESET_N_IN` mid-RELEASE, and separately cause 300 lock losses -> mid-RELEASE assertion immediately forces all outputs to their reset values; the counter saturates at 255.

Source files
------------

// File: rtl/reset_sequencer.sv
// Staged multi-domain reset sequencer: drives PLL reset, watches lock, and
// releases NUM_DOMAINS synchronous resets in order, re-sequencing on lock loss.
module reset_sequencer #(
   parameter int unsigned NUM_DOMAINS    = 4,
   parameter int unsigned PLL_RST_CYCLES = 16,
   parameter int unsigned STRETCH_CYCLES = 32,
   parameter int unsigned STAGE_DELAY    = 8,
   parameter int unsigned LOCK_TIMEOUT   = 65535,
   parameter int unsigned SYNC_STAGES    = 2
) (
   input  logic                   CLK_IN,
   input  logic                   RESET_N_IN,
   input  logic                   LOCKED_IN,
   input  logic                   SW_RESET_IN,
   output logic                   PLL_RESET_OUT,
   output logic [NUM_DOMAINS-1:0] RESET_OUT,
   output logic                   READY_OUT,
   output logic [7:0]             LOCK_LOSS_COUNT_OUT,
   output logic [2:0]             STATE_OUT
);

   localparam int unsigned MAX_A   = (PLL_RST_CYCLES > STRETCH_CYCLES) ? PLL_RST_CYCLES : STRETCH_CYCLES;
   localparam int unsigned MAX_B   = (STAGE_DELAY > LOCK_TIMEOUT) ? STAGE_DELAY : LOCK_TIMEOUT;
   localparam int unsigned MAX_CYC = (MAX_A > MAX_B) ? MAX_A : MAX_B;
   localparam int unsigned CNT_W   = $clog2(MAX_CYC);
   localparam int unsigned IDX_W   = $clog2(NUM_DOMAINS + 1);
   localparam int unsigned LAST_IDX = (NUM_DOMAINS > 1) ? NUM_DOMAINS - 2 : 0;

   localparam logic [CNT_W-1:0] PLL_LAST = CNT_W'(PLL_RST_CYCLES - 1);
   localparam logic [CNT_W-1:0] STR_LAST = CNT_W'(STRETCH_CYCLES - 1);
   localparam logic [CNT_W-1:0] STG_LAST = CNT_W'(STAGE_DELAY - 1);
   localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(LOCK_TIMEOUT - 1);
   localparam logic [NUM_DOMAINS-1:0] ALL_ONES = '1;

   typedef enum logic [2:0] {
      PLL_RST   = 3'd0,
      WAIT_LOCK = 3'd1,
      STRETCH   = 3'd2,
      RELEASE   = 3'd3,
      RUN       = 3'd4
   } state_t;

   state_t                 state;
   logic [CNT_W-1:0]       cnt;
   logic [IDX_W-1:0]       idx;
   logic [SYNC_STAGES-1:0] rst_sync;
   logic [SYNC_STAGES-1:0] lock_sync;
   logic                   rst_n;
   logic                   lock_s;

   // Assertion is immediate, deassertion ripples through the synchroniser.
   always_ff @(posedge CLK_IN or negedge RESET_N_IN) begin
      if (!RESET_N_IN) begin
         rst_sync  <= '0;
         lock_sync <= '0;
      end else begin
         rst_sync  <= {rst_sync[SYNC_STAGES-2:0], 1'b1};
         lock_sync <= {lock_sync[SYNC_STAGES-2:0], LOCKED_IN};
      end
   end

   assign rst_n     = rst_sync[SYNC_STAGES-1];
   assign lock_s    = lock_sync[SYNC_STAGES-1];
   assign STATE_OUT = state;

   always_ff @(posedge CLK_IN or negedge rst_n) begin
      if (!rst_n) begin
         state               <= PLL_RST;
         cnt                 <= '0;
         idx                 <= '0;
         PLL_RESET_OUT       <= 1'b1;
         RESET_OUT           <= '1;
         READY_OUT           <= 1'b0;
         LOCK_LOSS_COUNT_OUT <= '0;
      end else begin
         cnt <= cnt + 1'b1;
         case (state)
            PLL_RST: begin
               PLL_RESET_OUT <= 1'b1;
               RESET_OUT     <= '1;
               READY_OUT     <= 1'b0;
               if (cnt == PLL_LAST) begin
                  state         <= WAIT_LOCK;
                  cnt           <= '0;
                  PLL_RESET_OUT <= 1'b0;
               end
            end
            WAIT_LOCK: begin
               if (lock_s) begin
                  state <= STRETCH;
                  cnt   <= '0;
               end else if (cnt == TO_LAST) begin
                  state         <= PLL_RST;
                  cnt           <= '0;
                  PLL_RESET_OUT <= 1'b1;
               end
            end
            STRETCH: begin
               if (!lock_s) begin
                  state <= WAIT_LOCK;
                  cnt   <= '0;
               end else if (SW_RESET_IN) begin
                  cnt <= '0;
               end else if (cnt == STR_LAST) begin
                  cnt       <= '0;
                  idx       <= '0;
                  RESET_OUT <= ALL_ONES << 1;
                  if (NUM_DOMAINS == 1) begin
                     READY_OUT <= 1'b1;
                     state     <= RUN;
                  end else begin
                     state <= RELEASE;
                  end
               end
            end
            RELEASE, RUN: begin
               if (!lock_s) begin
                  state     <= WAIT_LOCK;
                  cnt       <= '0;
                  RESET_OUT <= '1;
                  READY_OUT <= 1'b0;
                  if (LOCK_LOSS_COUNT_OUT != 8'hFF)
                     LOCK_LOSS_COUNT_OUT <= LOCK_LOSS_COUNT_OUT + 1'b1;
               end else if (SW_RESET_IN) begin
                  state     <= STRETCH;
                  cnt       <= '0;
                  RESET_OUT <= '1;
                  READY_OUT <= 1'b0;
               end else if (state == RUN) begin
                  cnt <= '0;
               end else if (cnt == STG_LAST) begin
                  // Shifting keeps release monotonic: low bits always clear first.
                  cnt       <= '0;
                  RESET_OUT <= RESET_OUT << 1;
                  idx       <= idx + 1'b1;
                  if (idx == IDX_W'(LAST_IDX)) begin
                     READY_OUT <= 1'b1;
                     state     <= RUN;
                  end
               end
            end
            default: begin
               state         <= PLL_RST;
               cnt           <= '0;
               PLL_RESET_OUT <= 1'b1;
               RESET_OUT     <= '1;
               READY_OUT     <= 1'b0;
            end
         endcase
      end
   end

endmodule
